prog_clk_divider: RTL and testbench



---
 rtl/prog_clk_divider_if.sv | 22 ++
 rtl/prog_clk_divider.sv | 130 +++++++++++++
 tb/tb_prog_clk_divider.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/prog_clk_divider_if.sv
// Control/status bundle of the programmable clock divider.
// The divider takes the slave view; whatever drives en/div_ratio takes the master view.
interface prog_clk_divider_if #(
    parameter int WIDTH = 8
);
    logic             en;
    logic [WIDTH-1:0] div_ratio;
    logic             clk_out;
    logic             tick;
    logic             busy;
    logic             div_err;

    modport master (
        output en, div_ratio,
        input  clk_out, tick, busy, div_err
    );

    modport slave (
        input  en, div_ratio,
        output clk_out, tick, busy, div_err
    );
endinterface

// File: rtl/prog_clk_divider.sv
// Runtime-programmable integer clock divider with 50% duty for even and odd ratios.
// clk_out is the XOR of a rising-edge toggle and two fall toggles (posedge for even N, negedge for odd N).
//
//   state   | meaning
//   --------+---------------------------------------------------------------
//   ST_IDLE | stopped: busy=0, cnt=0, clk_out=0, ratio re-latched every edge
//   ST_RUN  | period in progress: cnt counts 0..div_q-1, boundary at div_q-1
module prog_clk_divider #(
    parameter int WIDTH     = 8,
    parameter int RESET_DIV = 5
) (
    input  logic                i_clk_in,
    input  logic                i_reset,
    prog_clk_divider_if.slave   io_div
);

    localparam logic [WIDTH-1:0] ONE_W       = WIDTH'(1);
    localparam logic [WIDTH-1:0] TWO_W       = WIDTH'(2);
    localparam logic [WIDTH-1:0] RESET_DIV_W = WIDTH'(RESET_DIV);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] w_cnt_nxt;
    logic [WIDTH-1:0] r_div_q;
    logic [WIDTH-1:0] w_div_q_nxt;
    logic             r_div_err;
    logic             w_div_err_nxt;
    logic             r_tick;
    logic             w_tick_nxt;
    logic             r_rise_t;
    logic             r_fall_p;
    logic             r_fall_n;
    logic             w_rise_en;
    logic             w_fall_p_en;
    logic             w_fall_n_en;
    logic [WIDTH-1:0] w_last;
    logic [WIDTH-1:0] w_half;
    logic [WIDTH-1:0] w_half_up;
    logic             w_at_last;
    logic             w_legal;
    logic [WIDTH-1:0] w_ratio_c;

    assign w_last    = r_div_q - ONE_W;
    assign w_half    = r_div_q >> 1;
    assign w_half_up = w_half + ONE_W;
    assign w_at_last = (r_cnt == w_last);
    assign w_legal   = (io_div.div_ratio >= TWO_W);
    assign w_ratio_c = w_legal ? io_div.div_ratio : TWO_W;

    always_ff @(posedge i_clk_in) begin
        if (i_reset) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_div_q   <= RESET_DIV_W;
            r_div_err <= 1'b0;
            r_tick    <= 1'b0;
            r_rise_t  <= 1'b0;
            r_fall_p  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_div_q   <= w_div_q_nxt;
            r_div_err <= w_div_err_nxt;
            r_tick    <= w_tick_nxt;
            r_rise_t  <= r_rise_t ^ w_rise_en;
            r_fall_p  <= r_fall_p ^ w_fall_p_en;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_div_q_nxt   = r_div_q;
        w_div_err_nxt = r_div_err;
        w_tick_nxt    = 1'b0;
        w_rise_en     = 1'b0;
        w_fall_p_en   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_div_q_nxt   = w_ratio_c;
                w_div_err_nxt = !w_legal;
                if (io_div.en) begin
                    w_state_nxt = ST_RUN;
                    w_cnt_nxt   = ONE_W;
                    w_rise_en   = 1'b1;
                end
            end
            ST_RUN: begin
                w_rise_en   = (r_cnt == '0);
                w_fall_p_en = !r_div_q[0] && (r_cnt == w_half);
                // The ratio only moves at the boundary so a period always finishes with its own N.
                if (w_at_last) begin
                    w_div_q_nxt   = w_ratio_c;
                    w_div_err_nxt = !w_legal;
                    w_cnt_nxt     = '0;
                    if (io_div.en) begin
                        w_tick_nxt = 1'b1;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + ONE_W;
                end
            end
        endcase
    end

    // Odd N: the fall lands mid-cycle while cnt holds (N+1)/2.
    assign w_fall_n_en = (r_state == ST_RUN) && r_div_q[0] && (r_cnt == w_half_up);

    always_ff @(negedge i_clk_in) begin
        if (i_reset) begin
            r_fall_n <= 1'b0;
        end else begin
            r_fall_n <= r_fall_n ^ w_fall_n_en;
        end
    end

    assign io_div.clk_out = r_rise_t ^ r_fall_p ^ r_fall_n;
    assign io_div.tick    = r_tick;
    assign io_div.busy    = (r_state == ST_RUN);
    assign io_div.div_err = r_div_err;

endmodule

// File: tb/tb_prog_clk_divider.sv
// Bench for prog_clk_divider: a half-cycle waveform queue predicts clk_out/busy/tick, plus the latched div_err.
// Each period of ratio N is N high half-cycles followed by N low half-cycles.
module tb_prog_clk_divider;

    localparam int WIDTH = 8;

    typedef struct packed {
        logic clk_out;
        logic busy;
        logic tick;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    prog_clk_divider_if #(.WIDTH(WIDTH)) dif ();

    prog_clk_divider #(
        .WIDTH     (WIDTH),
        .RESET_DIV (5)
    ) dut (
        .i_clk_in (clk),
        .i_reset  (rst),
        .io_div   (dif)
    );

    exp_t q[$];
    int   n_assert = 0;
    int   n_fail   = 0;
    int   m_n      = 5;
    bit   m_err    = 1'b0;
    bit   m_cont   = 1'b0;
    bit   rst_edge = 1'b0;

    function automatic int coerce(input int r);
        return (r < 2) ? 2 : r;
    endfunction

    task automatic chk(input string tag, input logic obs, input logic expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0b expected %0b at %0t", tag, obs, expv, $time);
        end
    endtask

    // Advance the reference model on a rising edge using the inputs it samples.
    task automatic model_edge();
        exp_t e0;
        exp_t e1;
        int   r;
        r = int'(dif.div_ratio);
        if (rst) begin
            q.delete();
            m_cont   = 1'b0;
            m_err    = 1'b0;
            m_n      = 5;
            rst_edge = 1'b1;
        end else begin
            rst_edge = 1'b0;
            if (q.size() == 2) begin
                m_n   = coerce(r);
                m_err = (r < 2);
                e0 = q.pop_front();
                e1 = q.pop_front();
                e0.busy = dif.en;
                e0.tick = dif.en;
                e1.busy = dif.en;
                e1.tick = dif.en;
                q.push_back(e0);
                q.push_back(e1);
                m_cont = dif.en;
            end else if (q.size() == 0) begin
                if (!m_cont) begin
                    m_n   = coerce(r);
                    m_err = (r < 2);
                end
                if (m_cont || dif.en) begin
                    for (int h = 0; h < 2 * m_n; h++) begin
                        e0.clk_out = (h < m_n);
                        e0.busy    = 1'b1;
                        e0.tick    = 1'b0;
                        q.push_back(e0);
                    end
                end
                m_cont = 1'b0;
            end
        end
    endtask

    task automatic cycle();
        exp_t e;
        @(posedge clk);
        model_edge();
        #1;
        e = '0;
        if (q.size() > 0) e = q.pop_front();
        if (!rst_edge) chk("clk_out_hi_phase", dif.clk_out, e.clk_out);
        chk("busy", dif.busy, e.busy);
        chk("tick", dif.tick, e.tick);
        chk("div_err", dif.div_err, m_err);
        @(negedge clk);
        #1;
        e = '0;
        if (q.size() > 0) e = q.pop_front();
        chk("clk_out_lo_phase", dif.clk_out, e.clk_out);
        chk("busy_lo_phase", dif.busy, e.busy);
        chk("tick_lo_phase", dif.tick, e.tick);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        int  k;
        bit  found;
        rst           = 1'b1;
        dif.en        = 1'b0;
        dif.div_ratio = 8'd5;
        run(2);
        rst = 1'b0;
        run(2);

        // N=5 from reset, then N=4
        dif.en = 1'b1;
        run(22);
        dif.div_ratio = 8'd4;
        run(16);

        // N=5 with a mid-period switch to 3
        dif.div_ratio = 8'd5;
        run(7);
        run($urandom_range(1, 4));
        dif.div_ratio = 8'd3;
        run(15);

        // N=6, stop mid-period, restart
        dif.div_ratio = 8'd6;
        run(14);
        run($urandom_range(0, 5));
        dif.en = 1'b0;
        run(10);
        dif.en = 1'b1;
        run(14);

        // illegal ratios coerced to 2, then recovery with 7
        dif.div_ratio = 8'd1;
        run(10);
        dif.div_ratio = 8'd0;
        run(8);
        dif.div_ratio = 8'd7;
        run(22);

        // largest ratio, then reset during the high phase
        dif.div_ratio = 8'd255;
        run(560);
        found = 1'b0;
        k = 0;
        while (!found && k < 600) begin
            cycle();
            k++;
            if (q.size() > 2 * 255 - 120 && q.size() < 2 * 255 - 40) found = 1'b1;
        end
        n_assert++;
        assert (found) else begin
            n_fail++;
            $error("FAIL wait_mid_high: observed timeout after %0d cycles expected high phase", k);
        end
        rst           = 1'b1;
        dif.div_ratio = 8'd5;
        cycle();
        rst = 1'b0;
        run(20);

        // randomized tail
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 5) == 0) dif.div_ratio = 8'($urandom_range(0, 12));
            dif.en = ($urandom_range(0, 9) != 0);
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
